// File: rtl/mux_sel_scan_module_if.sv
// Control and status bundle between a scan controller and the mux select generator.
// The master drives scan commands; the slave returns the select and its status flags.
interface mux_sel_scan_module_if #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 4
);
   logic               start;
   logic               stop;
   logic               dir;
   logic               one_pass;
   logic [DWELL_W-1:0] dwell;
   logic               load_en;
   logic [SEL_W-1:0]   load_sel;
   logic [SEL_W-1:0]   sel;
   logic               sel_valid;
   logic               busy;
   logic               wrap;
   logic               done;

   modport master (
      output start, stop, dir, one_pass, dwell, load_en, load_sel,
      input  sel, sel_valid, busy, wrap, done
   );

   modport slave (
      input  start, stop, dir, one_pass, dwell, load_en, load_sel,
      output sel, sel_valid, busy, wrap, done
   );
endinterface

// File: rtl/mux_sel_scan_module.sv
// Select generator for a 4:1 mux: steps sel up/down with a per-channel dwell and
// drops sel_valid for one settle cycle after every select change; all outputs registered.
module mux_sel_scan_module #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_sel_scan_module_if.slave  bus
);

   localparam logic [SEL_W-1:0]   SEL_ONE   = SEL_W'(1);
   localparam logic [SEL_W-1:0]   SEL_MAX   = {SEL_W{1'b1}};
   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

   typedef enum logic [1:0] {
      SETTLE_I,
      IDLE,
      DWELL,
      SETTLE_R
   } state_t;

   state_t             state;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   steps;
   logic [DWELL_W-1:0] dwell_r;
   logic [DWELL_W-1:0] cnt;
   logic               dir_r;
   logic               one_pass_r;
   logic               sel_valid_q;
   logic               busy_q;
   logic               wrap_q;
   logic               done_q;

   logic [SEL_W-1:0]   sel_next;
   logic               sel_wraps;
   logic               dwell_end;
   logic               last_chan;

   always_comb begin
      sel_next  = dir_r ? (sel_q - SEL_ONE) : (sel_q + SEL_ONE);
      sel_wraps = dir_r ? (sel_q == '0) : (sel_q == SEL_MAX);
      dwell_end = (cnt == (dwell_r - DWELL_ONE));
      // steps counts completed moves, so N-1 means the final channel is on the bus
      last_chan = one_pass_r && (steps == SEL_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SETTLE_I;
         sel_q       <= '0;
         steps       <= '0;
         dwell_r     <= '0;
         cnt         <= '0;
         dir_r       <= 1'b0;
         one_pass_r  <= 1'b0;
         sel_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         wrap_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            SETTLE_I: begin
               state       <= IDLE;
               sel_valid_q <= 1'b1;
               busy_q      <= 1'b0;
            end

            IDLE: begin
               if (bus.load_en) begin
                  // settle even when the value is unchanged so the consumer sees a uniform gap
                  sel_q       <= bus.load_sel;
                  state       <= SETTLE_I;
                  sel_valid_q <= 1'b0;
               end else if (bus.start && !bus.stop) begin
                  dwell_r     <= (bus.dwell == '0) ? DWELL_ONE : bus.dwell;
                  dir_r       <= bus.dir;
                  one_pass_r  <= bus.one_pass;
                  cnt         <= '0;
                  steps       <= '0;
                  state       <= DWELL;
                  busy_q      <= 1'b1;
                  sel_valid_q <= 1'b1;
               end
            end

            DWELL: begin
               if (bus.stop) begin
                  state       <= IDLE;
                  busy_q      <= 1'b0;
                  sel_valid_q <= 1'b1;
               end else if (dwell_end) begin
                  cnt <= '0;
                  if (last_chan) begin
                     state       <= IDLE;
                     busy_q      <= 1'b0;
                     sel_valid_q <= 1'b1;
                     done_q      <= 1'b1;
                  end else begin
                     sel_q       <= sel_next;
                     steps       <= steps + SEL_ONE;
                     wrap_q      <= sel_wraps;
                     state       <= SETTLE_R;
                     sel_valid_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + DWELL_ONE;
               end
            end

            SETTLE_R: begin
               sel_valid_q <= 1'b1;
               if (bus.stop) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state <= DWELL;
               end
            end

            default: begin
               state       <= SETTLE_I;
               sel_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel       = sel_q;
   assign bus.sel_valid = sel_valid_q;
   assign bus.busy      = busy_q;
   assign bus.wrap      = wrap_q;
   assign bus.done      = done_q;

endmodule
